// File: rtl/calc_display_driver_if.sv
// calc_display_driver_if: value/code inputs and multiplexed display outputs of calc_display_driver.
interface calc_display_driver_if;
  logic [7:0] ValueOut;
  logic [2:0] Display;
  logic       Overflow;
  logic [6:0] Segments;
  logic [3:0] Anodes;
  logic       Dp;
  logic       Busy;
  modport master (output ValueOut, Display, Overflow, input Segments, Anodes, Dp, Busy);
  modport slave (input ValueOut, Display, Overflow, output Segments, Anodes, Dp, Busy);
endinterface

// File: rtl/calc_display_driver.sv
// calc_display_driver: double-dabble binary-to-BCD conversion feeding a 4-digit multiplexed seven-segment display.
module calc_display_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input logic clock,
  input logic Reset_n,
  calc_display_driver_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state;
  logic [7:0] snap_val, bin, adj;
  logic [2:0] snap_code, disp_code, iter;
  logic valid, busy, dp, idle_code, h_zero, wrap;
  logic [11:0] bcd;
  logic [3:0] dig_h, dig_t, dig_u, an, cur_dig;
  logic [6:0] seg, letter;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  // hundreds never exceeds 2 for an 8-bit value, so only tens and units need the +3 correction
  assign adj[3:0] = bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0];
  assign adj[7:4] = bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4];
  assign idle_code = snap_code == 3'b100;
  assign h_zero = bcd[11:8] == 4'd0;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign letter = disp_code == 3'b001 ? 7'b0001000 :
                  disp_code == 3'b010 ? 7'b0000011 :
                  disp_code == 3'b011 ? 7'b0101111 :
                  disp_code == 3'b100 ? 7'b0111111 : 7'b1111111;
  assign cur_dig = idx == 2'd2 ? dig_h : idx == 2'd1 ? dig_t : dig_u;
  assign bus.Segments = seg;
  assign bus.Anodes = an;
  assign bus.Dp = dp;
  assign bus.Busy = busy;
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      snap_val <= '0;
      snap_code <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      bcd <= '0;
      bin <= '0;
      iter <= '0;
      dig_h <= 4'hF;
      dig_t <= 4'hF;
      dig_u <= 4'hF;
      disp_code <= '0;
    end else begin
      case (state)
        IDLE: if (!valid || {bus.ValueOut, bus.Display} != {snap_val, snap_code}) begin
          snap_val <= bus.ValueOut;
          snap_code <= bus.Display;
          bin <= bus.ValueOut;
          bcd <= '0;
          iter <= '0;
          busy <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd[10:8], adj, bin, 1'b0};
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= LATCH;
        end
        LATCH: begin
          // blanking is resolved here so the scan side only ever sees finished digits (4'hF = blank)
          dig_h <= idle_code || h_zero ? 4'hF : bcd[11:8];
          dig_t <= idle_code || (h_zero && bcd[7:4] == 4'd0) ? 4'hF : bcd[7:4];
          dig_u <= idle_code ? 4'hF : bcd[3:0];
          disp_code <= snap_code;
          valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
      idx <= '0;
      an <= 4'b1111;
      seg <= 7'b1111111;
      dp <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 2'd1 : idx;
      an <= ~(4'b0001 << idx);
      seg <= idx == 2'd3 ? letter : digit_seg(cur_dig);
      dp <= !(idx == 2'd0 && bus.Overflow && disp_code == 3'b011);
    end
  end
endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver: directed self-checking bench for calc_display_driver with a short refresh divider.
module tb_calc_display_driver;
  localparam int RD = 4;
  logic clock = 1'b0;
  logic Reset_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [6:0] cap [4];
  bit to;
  calc_display_driver_if bus();
  calc_display_driver #(.REFRESH_DIV(RD)) dut (.clock(clock), .Reset_n(Reset_n), .bus(bus));
  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle(output bit t);
    int n = 0;
    step(1);
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step(1);
    end
    t = bus.Busy !== 1'b0;
  endtask

  task automatic capture;
    for (int i = 0; i < 4; i++) cap[i] = 'x;
    for (int k = 0; k < 4 * RD + 4; k++) begin
      step(1);
      case (bus.Anodes)
        4'b1110: cap[0] = bus.Segments;
        4'b1101: cap[1] = bus.Segments;
        4'b1011: cap[2] = bus.Segments;
        4'b0111: cap[3] = bus.Segments;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset;
    int n = 0;
    bus.ValueOut = 8'd0; bus.Display = 3'b100; bus.Overflow = 1'b0; Reset_n = 1'b0;
    step(3);
    compared++; if (bus.Anodes !== 4'b1111) begin mismatched++; $display("FAIL reset_anodes: got %b want 1111", bus.Anodes); end
    compared++; if (bus.Segments !== 7'b1111111) begin mismatched++; $display("FAIL reset_segments: got %b want 1111111", bus.Segments); end
    compared++; if (bus.Dp !== 1'b1) begin mismatched++; $display("FAIL reset_dp: got %b want 1", bus.Dp); end
    compared++; if (bus.Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    Reset_n = 1'b1;
    step(1);
    while (bus.Busy === 1'b1 && n < 20) begin
      n++;
      step(1);
    end
    compared++; if (n != 9) begin mismatched++; $display("FAIL reset_busy_cycles: got %0d want 9", n); end
    step(1);
    capture;
    compared++; if (cap[3] !== 7'b0111111) begin mismatched++; $display("FAIL reset_letter: got %b want 0111111", cap[3]); end
    compared++; if (cap[2] !== 7'b1111111) begin mismatched++; $display("FAIL reset_hundreds: got %b want 1111111", cap[2]); end
    compared++; if (cap[1] !== 7'b1111111) begin mismatched++; $display("FAIL reset_tens: got %b want 1111111", cap[1]); end
    compared++; if (cap[0] !== 7'b1111111) begin mismatched++; $display("FAIL reset_units: got %b want 1111111", cap[0]); end
  endtask

  task automatic test_scan;
    logic [3:0] ea [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] es [4] = '{7'b0010010, 7'b0010010, 7'b0100100, 7'b0101111};
    int n = 0;
    bus.Display = 3'b011; bus.ValueOut = 8'd255;
    wait_idle(to);
    compared++; if (to) begin mismatched++; $display("FAIL scan_conv_timeout: busy=%b want 0", bus.Busy); end
    while (bus.Anodes !== 4'b0111 && n < 20) begin n++; step(1); end
    while (bus.Anodes === 4'b0111 && n < 40) begin n++; step(1); end
    compared++; if (bus.Anodes !== 4'b1110) begin mismatched++; $display("FAIL scan_sync: got %b want 1110", bus.Anodes); end
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < RD; k++) begin
        compared++; if (bus.Anodes !== ea[d]) begin mismatched++; $display("FAIL scan_anodes d%0d c%0d: got %b want %b", d, k, bus.Anodes, ea[d]); end
        compared++; if (bus.Segments !== es[d]) begin mismatched++; $display("FAIL scan_segments d%0d c%0d: got %b want %b", d, k, bus.Segments, es[d]); end
        step(1);
      end
    compared++; if (bus.Anodes !== 4'b1110) begin mismatched++; $display("FAIL scan_wrap: got %b want 1110", bus.Anodes); end
  endtask

  task automatic test_latency;
    bus.Display = 3'b001; bus.ValueOut = 8'd0;
    wait_idle(to);
    compared++; if (to) begin mismatched++; $display("FAIL lat_zero_timeout: busy=%b want 0", bus.Busy); end
    step(1);
    capture;
    compared++; if (cap[0] !== 7'b1000000) begin mismatched++; $display("FAIL zero_units: got %b want 1000000", cap[0]); end
    compared++; if (cap[1] !== 7'b1111111) begin mismatched++; $display("FAIL zero_tens: got %b want 1111111", cap[1]); end
    compared++; if (cap[2] !== 7'b1111111) begin mismatched++; $display("FAIL zero_hundreds: got %b want 1111111", cap[2]); end
    bus.ValueOut = 8'd7;
    step(1);
    for (int k = 1; k <= 9; k++) begin
      compared++; if (bus.Busy !== 1'b1) begin mismatched++; $display("FAIL lat_busy edge N+%0d: got %b want 1", k, bus.Busy); end
      step(1);
    end
    compared++; if (bus.Busy !== 1'b0) begin mismatched++; $display("FAIL lat_busy_done: got %b want 0", bus.Busy); end
    step(1);
    capture;
    compared++; if (cap[0] !== 7'b1111000) begin mismatched++; $display("FAIL lat_units: got %b want 1111000", cap[0]); end
    compared++; if (cap[1] !== 7'b1111111) begin mismatched++; $display("FAIL lat_tens: got %b want 1111111", cap[1]); end
    compared++; if (cap[2] !== 7'b1111111) begin mismatched++; $display("FAIL lat_hundreds: got %b want 1111111", cap[2]); end
    compared++; if (cap[3] !== 7'b0001000) begin mismatched++; $display("FAIL lat_letter: got %b want 0001000", cap[3]); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] tv [3][4] = '{
      '{7'b1111000, 7'b1111111, 7'b1111111, 7'b0001000},
      '{7'b0010010, 7'b1000000, 7'b1111001, 7'b0001000},
      '{7'b0100100, 7'b0011001, 7'b1111111, 7'b0001000}};
    int era, di;
    logic eb;
    bus.ValueOut = 8'd105;
    step(1);
    for (int k = 0; k < 30; k++) begin
      era = k >= 20 ? 2 : k >= 10 ? 1 : 0;
      di = bus.Anodes === 4'b1110 ? 0 : bus.Anodes === 4'b1101 ? 1 : bus.Anodes === 4'b1011 ? 2 : bus.Anodes === 4'b0111 ? 3 : 4;
      eb = (k <= 8) || (k >= 10 && k <= 18);
      compared++;
      if (di > 3) begin mismatched++; $display("FAIL b2b_anodes k%0d: got %b want one-low", k, bus.Anodes); end
      else if (bus.Segments !== tv[era][di]) begin mismatched++; $display("FAIL b2b_segments k%0d digit%0d: got %b want %b", k, di, bus.Segments, tv[era][di]); end
      compared++; if (bus.Busy !== eb) begin mismatched++; $display("FAIL b2b_busy k%0d: got %b want %b", k, bus.Busy, eb); end
      if (k == 3) bus.ValueOut = 8'd42;
      step(1);
    end
  endtask

  task automatic test_dp;
    int lows = 0;
    bus.Display = 3'b011; bus.Overflow = 1'b1; bus.ValueOut = 8'd0;
    wait_idle(to);
    compared++; if (to) begin mismatched++; $display("FAIL dp_conv_timeout: busy=%b want 0", bus.Busy); end
    step(2);
    for (int k = 0; k < 4 * RD; k++) begin
      if (bus.Dp === 1'b0) lows++;
      compared++; if (bus.Dp !== (bus.Anodes === 4'b1110 ? 1'b0 : 1'b1)) begin mismatched++; $display("FAIL dp_result c%0d: got %b want %b (anodes %b)", k, bus.Dp, bus.Anodes === 4'b1110 ? 1'b0 : 1'b1, bus.Anodes); end
      if (bus.Anodes === 4'b1110) begin
        compared++; if (bus.Segments !== 7'b1000000) begin mismatched++; $display("FAIL dp_units c%0d: got %b want 1000000", k, bus.Segments); end
      end
      step(1);
    end
    compared++; if (lows != RD) begin mismatched++; $display("FAIL dp_low_count: got %0d want %0d", lows, RD); end
    bus.Display = 3'b010;
    wait_idle(to);
    compared++; if (to) begin mismatched++; $display("FAIL dp_b_timeout: busy=%b want 0", bus.Busy); end
    step(2);
    lows = 0;
    for (int k = 0; k < 4 * RD; k++) begin
      if (bus.Dp !== 1'b1) lows++;
      step(1);
    end
    compared++; if (lows != 0) begin mismatched++; $display("FAIL dp_operand_b: got %0d low cycles want 0", lows); end
    bus.Overflow = 1'b0;
  endtask

  task automatic test_letter_reset;
    bus.Display = 3'b111; bus.ValueOut = 8'd9;
    wait_idle(to);
    compared++; if (to) begin mismatched++; $display("FAIL blank_conv_timeout: busy=%b want 0", bus.Busy); end
    step(1);
    capture;
    compared++; if (cap[3] !== 7'b1111111) begin mismatched++; $display("FAIL blank_letter: got %b want 1111111", cap[3]); end
    compared++; if (cap[0] !== 7'b0010000) begin mismatched++; $display("FAIL blank_units: got %b want 0010000", cap[0]); end
    compared++; if (cap[1] !== 7'b1111111) begin mismatched++; $display("FAIL blank_tens: got %b want 1111111", cap[1]); end
    bus.Display = 3'b100; bus.ValueOut = 8'd200;
    step(3);
    compared++; if (bus.Busy !== 1'b1) begin mismatched++; $display("FAIL midshift_busy: got %b want 1", bus.Busy); end
    #2 Reset_n = 1'b0;
    #1;
    compared++; if (bus.Anodes !== 4'b1111) begin mismatched++; $display("FAIL async_anodes: got %b want 1111", bus.Anodes); end
    compared++; if (bus.Segments !== 7'b1111111) begin mismatched++; $display("FAIL async_segments: got %b want 1111111", bus.Segments); end
    compared++; if (bus.Dp !== 1'b1) begin mismatched++; $display("FAIL async_dp: got %b want 1", bus.Dp); end
    compared++; if (bus.Busy !== 1'b0) begin mismatched++; $display("FAIL async_busy: got %b want 0", bus.Busy); end
    bus.Display = 3'b000; bus.ValueOut = 8'd0;
    step(2);
    Reset_n = 1'b1;
    step(1);
    compared++; if (bus.Busy !== 1'b1) begin mismatched++; $display("FAIL rerun_busy: got %b want 1", bus.Busy); end
    wait_idle(to);
    compared++; if (to) begin mismatched++; $display("FAIL rerun_timeout: busy=%b want 0", bus.Busy); end
    step(1);
    capture;
    compared++; if (cap[0] !== 7'b1000000) begin mismatched++; $display("FAIL rerun_units: got %b want 1000000", cap[0]); end
    compared++; if (cap[3] !== 7'b1111111) begin mismatched++; $display("FAIL rerun_letter: got %b want 1111111", cap[3]); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_latency;
    test_back_to_back;
    test_dp;
    test_letter_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
- Consumer side of the calculator controller's display outputs: takes the 8-bit value and 3-bit display code and drives a 4-digit multiplexed seven-segment display.
- Value 0-255 is converted to decimal by an iterative shift-add-3 (double-dabble) engine and shown on digits 2..0 with leading-zero blanking.
- Digit 3 shows a mode letter derived from the display code.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit before the scan advances (minimum 2).

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- Reset_n  input  1  asynchronous active-low reset
- ValueOut  input  8  unsigned value to display
- Display  input  3  mode code: 100 idle, 001 operand A, 010 operand B, 011 result
- Overflow  input  1  result overflow flag
- Segments  output  7  active-low segments {g,f,e,d,c,b,a}
- Anodes  output  4  active-low digit enables; bit0 = rightmost (units), bit3 = letter digit
- Dp  output  1  active-low decimal point
- Busy  output  1  high while a conversion is in progress

Behaviour:
- Reset (async, Reset_n=0):
  - Anodes=1111, Segments=1111111, Dp=1, Busy=0.
  - Digit registers cleared to blank; snapshot cleared; valid flag=0.
  - FSM=IDLE; scan index=0; refresh counter=0.
- Conversion FSM, states IDLE, SHIFT, LATCH:
  - IDLE: if valid=0 or {ValueOut,Display} differs from the snapshot, then load snapshot, clear 12-bit BCD accumulator, set iteration count=0, go to SHIFT. Otherwise stay.
  - SHIFT: one iteration per cycle. Add 3 to each BCD nibble >=5, then shift {bcd,bin} left by 1. After the 8th iteration, go to LATCH.
  - LATCH: copy hundreds/tens/units and the snapshot code into the display registers atomically; set valid=1; go to IDLE.
  - Busy=1 in SHIFT and LATCH.
  - Latency: input change sampled at IDLE edge N; new digits visible from edge N+9 (8 SHIFT + 1 LATCH).
- Inputs changing during SHIFT/LATCH are ignored for the current conversion. The completed result is still latched; IDLE detects the mismatch on the next cycle and restarts. The displayed value never shows a partial or mixed conversion.
- Leading-zero blanking:
  - Hundreds blank if 0.
  - Tens blank if hundreds=0 and tens=0.
  - Units always shown. Value 0 shows "0"; value 7 shows "  7"; value 105 shows "105".
- Letter digit, by latched code:
  - 001 -> A (0001000)
  - 010 -> b (0000011)
  - 011 -> r (0101111)
  - 100 -> dash (0111111)
  - any other code -> blank (1111111)
- Idle code (100): hundreds/tens/units are blank regardless of value; only the dash is shown.
- Digit segment codes (active low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, scan index advances 0->1->2->3->0.
  - Exactly one Anodes bit is low at a time; Segments are registered in the same cycle as Anodes (no ghosting).
  - Scanning runs continuously and is independent of conversion.
- Dp: low only while digit 0 is active and Overflow=1 and latched code=011; otherwise 1. Overflow is sampled live, not latched.
- Reset asserted mid-conversion or mid-scan: immediate return to reset values. After release, the first IDLE cycle converts unconditionally (valid=0).

Test Plan:
- Reset held, then released with ValueOut=0, Display=100 -> Anodes=1111 and Busy=0 during reset; Busy high 9 cycles after release; then letter digit=0111111 and digits 2..0 blank.
- REFRESH_DIV=4, Display=011, ValueOut=255 -> Anodes cycles 1110,1101,1011,0111, each for 4 cycles. Segments: units 0010010, tens 0010010, hundreds 0100100, letter 0101111.
- Display=001, ValueOut changes 0->7 at edge N -> Busy=1 on edges N+1..N+9; digits read blank, blank, 1111000 from edge N+9; letter 0001000.
- ValueOut=105 then 42 applied 3 cycles into the conversion -> 105 is latched first; a second conversion starts immediately after; final digits blank, 0011001, 0100100 (42); no mixed value is ever shown.
- Display=011, Overflow=1, ValueOut=0 -> Dp=0 only while Anodes=1110; units show 1000000; with Display=010, Dp stays 1.
- Display=111 -> letter digit blank; Reset_n pulsed low mid-SHIFT -> outputs return to reset values within the same cycle, and a fresh conversion completes after release.
